// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID pipeline stage.
// A beat is the {pc, instr} pair carried from fetch to decode.
package if_id_pkg;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam int          BEAT_PC_W    = 32;
  localparam int          BEAT_INSTR_W = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_t;

  typedef struct packed {
    logic [BEAT_PC_W-1:0]    pc;
    logic [BEAT_INSTR_W-1:0] instr;
  } if_id_beat_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter that can be shared by pipeline stages.
// Counts cycles where inc is high and holds at all-ones; cleared only by reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/if_id_skid.sv
// IF/ID stage: two-entry skid buffer between fetch and decode with registered
// in_ready, synchronous flush, and a saturating decode back-pressure counter.
module if_id_skid
  import if_id_pkg::*;
#(
  parameter int                 PC_W      = 32,
  parameter int                 INSTR_W   = 32,
  parameter int                 CNT_W     = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = if_id_pkg::NOP_INSTR[INSTR_W-1:0]
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instr,
  output logic [CNT_W-1:0]   stall_cnt
);

  // Beat fields are 32 bits wide; wider payloads would be silently truncated.
  if (PC_W > BEAT_PC_W || INSTR_W > BEAT_INSTR_W) begin : g_width_check
    $error("if_id_skid: PC_W/INSTR_W exceed if_id_beat_t field widths");
  end

  occ_t        state_p0, state_nxt;
  logic        main_vld_p0, main_vld_nxt;
  logic        skid_vld_p0, skid_vld_nxt;
  if_id_beat_t main_p0, main_nxt;
  if_id_beat_t skid_p0, skid_nxt;
  if_id_beat_t in_beat, empty_beat;
  logic        in_fire, out_fire;

  assign in_beat    = '{pc: BEAT_PC_W'(in_pc), instr: BEAT_INSTR_W'(in_instr)};
  assign empty_beat = '{pc: '0, instr: BEAT_INSTR_W'(NOP_INSTR)};

  assign in_ready  = !skid_vld_p0;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = main_vld_p0 && out_ready;

  always_comb begin
    state_nxt    = state_p0;
    main_vld_nxt = main_vld_p0;
    skid_vld_nxt = skid_vld_p0;
    main_nxt     = main_p0;
    skid_nxt     = skid_p0;
    if (flush) begin
      state_nxt    = EMPTY;
      main_vld_nxt = 1'b0;
      skid_vld_nxt = 1'b0;
      main_nxt     = empty_beat;
      skid_nxt     = empty_beat;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_fire) begin
            main_nxt     = in_beat;
            main_vld_nxt = 1'b1;
            state_nxt    = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_nxt = in_beat;
          end else if (in_fire) begin
            skid_nxt     = in_beat;
            skid_vld_nxt = 1'b1;
            state_nxt    = TWO;
          end else if (out_fire) begin
            // Drained: main is reloaded so out_* shows the empty payload.
            main_nxt     = empty_beat;
            main_vld_nxt = 1'b0;
            state_nxt    = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            main_nxt     = skid_p0;
            skid_vld_nxt = 1'b0;
            state_nxt    = ONE;
          end
        end
        default: begin
          state_nxt    = EMPTY;
          main_vld_nxt = 1'b0;
          skid_vld_nxt = 1'b0;
          main_nxt     = empty_beat;
          skid_nxt     = empty_beat;
        end
      endcase
    end
  end

  // Stage p0: occupancy state, slot valid bits and slot payloads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_p0    <= EMPTY;
      main_vld_p0 <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      main_vld_p0 <= main_vld_nxt;
      skid_vld_p0 <= skid_vld_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_p0 <= empty_beat;
      skid_p0 <= empty_beat;
    end else begin
      main_p0 <= main_nxt;
      skid_p0 <= skid_nxt;
    end
  end

  assign out_valid = main_vld_p0;
  assign out_pc    = main_p0.pc[PC_W-1:0];
  assign out_instr = main_p0.instr[INSTR_W-1:0];

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (main_vld_p0 && !out_ready),
    .count  (stall_cnt)
  );

endmodule

// File: tb/tb_if_id_skid.sv
// Bench for if_id_skid: directed vector table, async-reset and saturation
// sequences, then random traffic against a queue-based reference model.
module tb_if_id_skid;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready, in_ready4;
  logic [31:0] in_pc, in_instr;
  logic        out_valid, out_valid4;
  logic        out_ready;
  logic [31:0] out_pc, out_instr, out_pc4, out_instr4;
  logic [15:0] stall_cnt;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_id_skid #(.PC_W(32), .INSTR_W(32), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .stall_cnt(stall_cnt)
  );

  if_id_skid #(.PC_W(32), .INSTR_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid4), .out_ready(out_ready), .out_pc(out_pc4), .out_instr(out_instr4),
    .stall_cnt(stall_cnt4)
  );

  // Reference model: FIFO of accepted beats, capacity two, plus stall counts.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } beat_t;

  beat_t q[$];
  int    m_cnt16 = 0;
  int    m_cnt4  = 0;

  typedef struct {
    logic        iv;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    logic        e_ir;
    int          e_cnt;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    beat_t h;
    h = (q.size() > 0) ? q[0] : '{pc: 32'h0, instr: NOP};
    chk("model_out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("model_in_ready",  64'(in_ready),  64'(q.size() < 2));
    chk("model_out_pc",    64'(out_pc),    64'(h.pc));
    chk("model_out_instr", 64'(out_instr), 64'(h.instr));
    chk("model_stall16",   64'(stall_cnt), 64'(m_cnt16));
    chk("model_stall4",    64'(stall_cnt4), 64'(m_cnt4));
    chk("model_dut4_pc",   64'(out_pc4),   64'(h.pc));
    chk("model_dut4_ir",   64'(in_ready4), 64'(q.size() < 2));
  endtask

  // Drive one cycle's inputs, advance the model, and step through the edge.
  task automatic apply(input logic iv, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    logic in_f, out_f;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    out_ready = ordy;
    flush     = fl;
    in_f  = iv && (q.size() < 2);
    out_f = (q.size() > 0) && ordy;
    if ((q.size() > 0) && !ordy) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
    if (fl) begin
      q.delete();
    end else begin
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back('{pc: pc, instr: ins});
    end
    @(posedge clk);
  endtask

  task automatic set_row(input int i, input logic iv, input logic [31:0] pc,
                         input logic [31:0] ins, input logic ordy, input logic fl,
                         input logic e_ov, input logic [31:0] e_pc, input logic [31:0] e_ins,
                         input logic e_ir, input int e_cnt);
    tbl[i] = '{iv, pc, ins, ordy, fl, e_ov, e_pc, e_ins, e_ir, e_cnt};
  endtask

  initial begin
    // Expected values are what is visible before this row's inputs take effect.
    set_row(0,  1, 32'h4,  32'hDEADBEEF, 1, 0, 0, 32'h0,  NOP,          1, 0);
    set_row(1,  1, 32'h8,  32'h12345678, 1, 0, 1, 32'h4,  32'hDEADBEEF, 1, 0);
    set_row(2,  1, 32'hC,  32'hCAFEF00D, 1, 0, 1, 32'h8,  32'h12345678, 1, 0);
    set_row(3,  0, 32'h0,  32'h0,        1, 0, 1, 32'hC,  32'hCAFEF00D, 1, 0);
    set_row(4,  0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  NOP,          1, 0);
    set_row(5,  1, 32'h4,  32'hDEADBEEF, 0, 0, 0, 32'h0,  NOP,          1, 0);
    set_row(6,  1, 32'h8,  32'h12345678, 0, 0, 1, 32'h4,  32'hDEADBEEF, 1, 0);
    set_row(7,  1, 32'hC,  32'hCAFEF00D, 0, 0, 1, 32'h4,  32'hDEADBEEF, 0, 1);
    set_row(8,  1, 32'hC,  32'hCAFEF00D, 0, 0, 1, 32'h4,  32'hDEADBEEF, 0, 2);
    set_row(9,  1, 32'hC,  32'hCAFEF00D, 1, 0, 1, 32'h4,  32'hDEADBEEF, 0, 3);
    set_row(10, 1, 32'hC,  32'hCAFEF00D, 1, 0, 1, 32'h8,  32'h12345678, 1, 3);
    set_row(11, 0, 32'h0,  32'h0,        1, 0, 1, 32'hC,  32'hCAFEF00D, 1, 3);
    set_row(12, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  NOP,          1, 3);
    set_row(13, 1, 32'h4,  32'hDEADBEEF, 0, 0, 0, 32'h0,  NOP,          1, 3);
    set_row(14, 1, 32'h8,  32'h12345678, 0, 0, 1, 32'h4,  32'hDEADBEEF, 1, 3);
    set_row(15, 1, 32'h10, 32'h0BADF00D, 0, 1, 1, 32'h4,  32'hDEADBEEF, 0, 4);
    set_row(16, 0, 32'h0,  32'h0,        1, 0, 0, 32'h0,  NOP,          1, 5);
    set_row(17, 1, 32'h14, 32'h11111111, 1, 0, 0, 32'h0,  NOP,          1, 5);
    set_row(18, 1, 32'h18, 32'h22222222, 0, 1, 1, 32'h14, 32'h11111111, 1, 5);
    set_row(19, 0, 32'h0,  32'h0,        1, 0, 0, 32'h0,  NOP,          1, 6);
    set_row(20, 1, 32'h1C, 32'h33333333, 1, 0, 0, 32'h0,  NOP,          1, 6);
    set_row(21, 0, 32'h0,  32'h0,        1, 0, 1, 32'h1C, 32'h33333333, 1, 6);
    set_row(22, 0, 32'h0,  32'h0,        1, 0, 0, 32'h0,  NOP,          1, 6);

    reset_n = 1'b0; flush = 0; in_valid = 0; in_pc = '0; in_instr = '0; out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_pc",    64'(out_pc),    64'h0);
    chk("rst_out_instr", 64'(out_instr), 64'(NOP));
    chk("rst_in_ready",  64'(in_ready),  64'h1);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'h0);

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      check_model();
      chk($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].e_ov));
      chk($sformatf("vec%0d_out_pc", i),    64'(out_pc),    64'(tbl[i].e_pc));
      chk($sformatf("vec%0d_out_instr", i), 64'(out_instr), 64'(tbl[i].e_instr));
      chk($sformatf("vec%0d_in_ready", i),  64'(in_ready),  64'(tbl[i].e_ir));
      chk($sformatf("vec%0d_stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].e_cnt));
      apply(tbl[i].iv, tbl[i].pc, tbl[i].instr, tbl[i].ordy, tbl[i].fl);
    end

    // Fill to two entries, then drop reset between clock edges.
    @(negedge clk); check_model(); apply(1, 32'h40, 32'hAAAA0001, 0, 0);
    @(negedge clk); check_model(); apply(1, 32'h44, 32'hAAAA0002, 0, 0);
    @(negedge clk); check_model();
    chk("pre_areset_in_ready", 64'(in_ready), 64'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'h0);
    chk("areset_out_pc",    64'(out_pc),    64'h0);
    chk("areset_out_instr", 64'(out_instr), 64'(NOP));
    chk("areset_in_ready",  64'(in_ready),  64'h1);
    chk("areset_stall_cnt", 64'(stall_cnt), 64'h0);
    chk("areset_stall_cnt4", 64'(stall_cnt4), 64'h0);
    q.delete(); m_cnt16 = 0; m_cnt4 = 0;
    in_valid = 0; out_ready = 0;
    @(negedge clk);
    reset_n = 1'b1;

    // Hold one beat with decode stalled long enough to saturate the 4-bit counter.
    @(negedge clk); check_model(); apply(1, 32'h80, 32'hBBBB0001, 0, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); check_model(); apply(0, 32'h0, 32'h0, 0, 0);
    end
    @(negedge clk);
    check_model();
    chk("sat_stall_cnt4",  64'(stall_cnt4), 64'd15);
    chk("sat_stall_cnt16", 64'(stall_cnt),  64'd20);
    chk("sat_held_pc",     64'(out_pc),     64'h80);
    apply(0, 32'h0, 32'h0, 0, 0);
    @(negedge clk);
    chk("sat_stall_cnt4_hold", 64'(stall_cnt4), 64'd15);
    apply(0, 32'h0, 32'h0, 1, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      logic        iv, ordy, fl;
      logic [31:0] pc, ins;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      pc   = $urandom & 32'hFFFF_FFFC;
      ins  = $urandom;
      @(negedge clk);
      check_model();
      apply(iv, pc, ins, ordy, fl);
    end
    @(negedge clk);
    check_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
# if_id_skid

Parametrised IF/ID pipeline stage with a valid/ready handshake on both sides. It carries PC and instruction from fetch to decode. A two-entry skid buffer sustains one beat per cycle with a fully registered `in_ready`. A synchronous flush kills in-flight instructions, and a saturating counter records decode back-pressure cycles.

## Interface
- `PC_W`, 32, PC width in bits.
- `INSTR_W`, 32, instruction width in bits.
- `CNT_W`, 16, stall counter width.
- `NOP_INSTR`, `if_id_pkg::NOP_INSTR` (32'h00000013), payload presented when the stage is empty.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous kill of all held beats.
- `in_valid`  in  1  fetch presents a beat.
- `in_ready`  out  1  stage can accept a beat; registered.
- `in_pc`  in  PC_W  fetch PC.
- `in_instr`  in  INSTR_W  fetched instruction.
- `out_valid`  out  1  decode beat valid.
- `out_ready`  in  1  decode accepts the beat.
- `out_pc`  out  PC_W  PC to decode.
- `out_instr`  out  INSTR_W  instruction to decode.
- `stall_cnt`  out  CNT_W  saturating count of back-pressure cycles.

## Operation
- Input fire = `in_valid && in_ready`. Output fire = `out_valid && out_ready`.
- Storage: main slot (drives `out_*`) plus skid slot. Each slot has its own valid bit.
- Occupancy states, encoded as `occ_t`: EMPTY, ONE, TWO.
  - EMPTY: input fire loads main and moves to ONE.
  - ONE, input and output fire together: main takes the new input; stay in ONE.
  - ONE, input fire only: skid takes the new input; move to TWO.
  - ONE, output fire only: move to EMPTY.
  - TWO: `in_ready` is 0. Output fire copies skid into main and moves to ONE.
- `in_ready` = registered `!skid_valid`, so it is 1 in EMPTY and ONE. There is no combinational path from `out_ready` to `in_ready`.
- `out_valid` = main valid bit.
- Empty payload: when main is not valid, `out_pc` = 0 and `out_instr` = NOP_INSTR.
- Flush:
  - Next state is EMPTY and both valid bits clear.
  - Payload registers load 0 / NOP_INSTR.
  - `flush` has priority over any input fire or output fire in the same cycle. A beat accepted in that cycle is discarded.
- Beats leave in strict arrival order. No beat is duplicated or dropped, except by flush.
- `stall_cnt`:
  - Increments every cycle in which `out_valid && !out_ready` holds.
  - Saturates at all-ones.
  - Cleared only by reset; flush does not clear it.

## Timing
- Reset values (asserted asynchronously):
  - `out_valid` = 0, `in_ready` = 1.
  - `out_pc` = 0, `out_instr` = NOP_INSTR.
  - `stall_cnt` = 0, state EMPTY.
- Latency: input fire at edge N gives `out_valid` = 1 with that payload after edge N, visible in cycle N+1.
- Throughput: 1 beat/cycle while `out_ready` is held at 1.
- Back-pressure: `in_ready` falls one cycle after the skid slot fills.
  - At most 2 beats are accepted after `out_ready` drops: one already in main, one in skid.
- Release: `in_ready` rises one cycle after the output fire that drains skid.
- `out_*` must hold stable while `out_valid && !out_ready`.
- Reset asserted mid-operation: all held beats are lost immediately. Outputs take reset values without waiting for a clock edge.
- Reset release is synchronised externally. The block needs no extra cycle after reset release.

## Structure
- Shared package `if_id_pkg` contains:
  - `NOP_INSTR` constant.
  - `occ_t` enum (EMPTY/ONE/TWO).
  - Packed struct `if_id_beat_t` {pc, instr}, used for both slots.
- Sub-module `sat_counter` (parameter CNT_W; ports clk, reset_n, inc, count) implements `stall_cnt`. It is reusable by other pipeline stages.
- Everything else sits in one module: slot registers, valid bits, next-state logic.

## Test plan
- Reset and idle: hold `reset_n` = 0 for 2 cycles, then release with `in_valid` = 0.
  - Expect `out_valid` = 0, `out_pc` = 0, `out_instr` = 32'h00000013, `in_ready` = 1, `stall_cnt` = 0.
- Streaming: `out_ready` = 1; drive pc 4/8/C with instructions DEADBEEF/12345678/CAFEF00D on consecutive cycles.
  - Each beat appears one cycle later, in order.
  - `in_ready` stays 1 and `stall_cnt` stays 0.
- Back-pressure: `out_ready` = 0 while streaming pc 4, 8, C.
  - pc 4 and pc 8 are accepted; `in_ready` = 0 from the next cycle; pc C is held by fetch.
  - `stall_cnt` increments each stalled cycle.
  - Raising `out_ready` delivers 4, 8, C in order, with no loss or duplication.
- Flush: with state TWO (pc 4, 8 held), assert `flush` together with `in_valid` carrying pc 10.
  - Next cycle: `out_valid` = 0, `out_instr` = NOP, `in_ready` = 1.
  - pc 10 never appears on the output.
- Saturation: CNT_W = 4, hold `out_valid` = 1 with `out_ready` = 0 for 20 cycles.
  - `stall_cnt` reaches 15 and stays at 15.
- Async reset mid-stall: assert `reset_n` = 0 between clock edges while in TWO.
  - Outputs take reset values before the next rising edge.
